// File: rtl/adder_amba_top.sv
// AXI4-Lite slave holding two operands, an add/subtract engine with a DONE flag,
// and an LED register. Address and data channels are latched independently.
module adder_amba_top #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [3:0]                        o_leds
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;

   localparam logic [2:0] ADDR_R0   = 3'd0;
   localparam logic [2:0] ADDR_R1   = 3'd1;
   localparam logic [2:0] ADDR_R2   = 3'd2;
   localparam logic [2:0] ADDR_CTRL = 3'd3;
   localparam logic [2:0] ADDR_LED  = 3'd4;

   logic          awready_q, awready_d, aw_held_q, aw_held_d;
   logic [2:0]    awaddr_q, awaddr_d;
   logic          wready_q, wready_d, w_held_q, w_held_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [SW-1:0] wstrb_q, wstrb_d;
   logic          bvalid_q, bvalid_d;
   logic          arready_q, arready_d;
   logic [2:0]    araddr_q, araddr_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, led_q, led_d;
   logic          op_q, op_d, done_q, done_d, calc_q, calc_d;
   logic          wr_en;
   logic [DW-1:0] rd_mux;
   logic          unused_ok;

   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
      logic [DW-1:0] res;
      res = old_v;
      for (int i = 0; i < SW; i++)
         if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   assign wr_en = aw_held_q && w_held_q && !bvalid_q;

   always_comb begin
      rd_mux = '0;
      case (araddr_q)
         ADDR_R0:   rd_mux = r0_q;
         ADDR_R1:   rd_mux = r1_q;
         ADDR_R2:   rd_mux = r2_q;
         ADDR_CTRL: rd_mux = {done_q, {(DW-3){1'b0}}, op_q, 1'b0};
         ADDR_LED:  rd_mux = led_q;
         default:   rd_mux = '0;
      endcase
   end

   always_comb begin
      awready_d = 1'b0;
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      wready_d  = 1'b0;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      arready_d = 1'b0;
      araddr_d  = araddr_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      r0_d      = r0_q;
      r1_d      = r1_q;
      r2_d      = r2_q;
      led_d     = led_q;
      op_d      = op_q;
      done_d    = done_q;
      calc_d    = 1'b0;

      if (S_AXI_AWVALID && !aw_held_q) begin
         awready_d = 1'b1;
         aw_held_d = 1'b1;
         awaddr_d  = S_AXI_AWADDR[4:2];
      end
      if (S_AXI_WVALID && !w_held_q) begin
         wready_d = 1'b1;
         w_held_d = 1'b1;
         wdata_d  = S_AXI_WDATA;
         wstrb_d  = S_AXI_WSTRB;
      end
      // Both halves stay latched until the response is taken, blocking new accepts.
      if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end

      if (calc_q) begin
         r2_d   = op_q ? (r0_q + r1_q) : (r0_q - r1_q);
         done_d = 1'b1;
      end

      if (wr_en) begin
         bvalid_d = 1'b1;
         case (awaddr_q)
            ADDR_R0:  r0_d  = merge_bytes(r0_q, wdata_q, wstrb_q);
            ADDR_R1:  r1_d  = merge_bytes(r1_q, wdata_q, wstrb_q);
            ADDR_LED: led_d = merge_bytes(led_q, wdata_q, wstrb_q);
            ADDR_CTRL: begin
               if (wstrb_q[0]) begin
                  op_d = wdata_q[1];
                  if (wdata_q[0]) begin
                     done_d = 1'b0;
                     calc_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      if (S_AXI_ARVALID && !rvalid_q && !arready_q) begin
         arready_d = 1'b1;
         araddr_d  = S_AXI_ARADDR[4:2];
      end
      if (arready_q) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end
      if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
      if (S_AXI_ARESETN) begin
         awready_q <= 1'b0;
         aw_held_q <= 1'b0;
         awaddr_q  <= '0;
         wready_q  <= 1'b0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         araddr_q  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         r0_q      <= '0;
         r1_q      <= '0;
         r2_q      <= '0;
         led_q     <= '0;
         op_q      <= 1'b0;
         done_q    <= 1'b0;
         calc_q    <= 1'b0;
      end else begin
         awready_q <= awready_d;
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         wready_q  <= wready_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         araddr_q  <= araddr_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         r0_q      <= r0_d;
         r1_q      <= r1_d;
         r2_q      <= r2_d;
         led_q     <= led_d;
         op_q      <= op_d;
         done_q    <= done_d;
         calc_q    <= calc_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign o_leds        = led_q[3:0];

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_adder_amba_top.sv
// Directed bench for adder_amba_top: register access, arithmetic, byte lanes,
// independent AW/W ordering, concurrent read/write and mid-transaction reset.
module tb_adder_amba_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID, WREADY;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;
   logic [4:0]  ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID, RREADY;
   logic [3:0]  leds;

   int tests = 0;
   int fails = 0;

   // bookkeeping from the most recent write
   int          aw_pulses, w_pulses;
   logic        b_after;
   logic [1:0]  last_bresp;
   logic [31:0] rd;
   logic [1:0]  rr;
   logic [31:0] rd_c;
   logic [1:0]  rr_c;

   always #5 clk = ~clk;

   adder_amba_top dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst),
      .S_AXI_AWADDR  (AWADDR),
      .S_AXI_AWPROT  (AWPROT),
      .S_AXI_AWVALID (AWVALID),
      .S_AXI_AWREADY (AWREADY),
      .S_AXI_WDATA   (WDATA),
      .S_AXI_WSTRB   (WSTRB),
      .S_AXI_WVALID  (WVALID),
      .S_AXI_WREADY  (WREADY),
      .S_AXI_BRESP   (BRESP),
      .S_AXI_BVALID  (BVALID),
      .S_AXI_BREADY  (BREADY),
      .S_AXI_ARADDR  (ARADDR),
      .S_AXI_ARPROT  (ARPROT),
      .S_AXI_ARVALID (ARVALID),
      .S_AXI_ARREADY (ARREADY),
      .S_AXI_RDATA   (RDATA),
      .S_AXI_RRESP   (RRESP),
      .S_AXI_RVALID  (RVALID),
      .S_AXI_RREADY  (RREADY),
      .o_leds        (leds)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // W is raised w_delay cycles after AW (0 = together).
   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_delay);
      logic got_b = 1'b0;
      logic w_sent;
      aw_pulses = 0;
      w_pulses  = 0;
      AWADDR  = addr;
      AWVALID = 1'b1;
      WDATA   = data;
      WSTRB   = strb;
      w_sent  = (w_delay == 0);
      WVALID  = w_sent;
      BREADY  = 1'b1;
      for (int c = 0; c < 40 && !got_b; c++) begin
         @(posedge clk); #1;
         if (AWREADY) begin aw_pulses++; AWVALID = 1'b0; end
         if (WREADY)  begin w_pulses++;  WVALID  = 1'b0; end
         if (BVALID)  begin got_b = 1'b1; last_bresp = BRESP; end
         if (!w_sent && c + 1 >= w_delay) begin WVALID = 1'b1; w_sent = 1'b1; end
      end
      chk("wr_done", {31'b0, got_b}, 32'd1);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      @(posedge clk); #1;
      b_after = BVALID;
      BREADY  = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      logic got_r = 1'b0;
      data = 32'hDEAD_BEEF;
      resp = 2'b11;
      ARADDR  = addr;
      ARVALID = 1'b1;
      RREADY  = 1'b1;
      for (int c = 0; c < 40 && !got_r; c++) begin
         @(posedge clk); #1;
         if (ARREADY) ARVALID = 1'b0;
         if (RVALID) begin got_r = 1'b1; data = RDATA; resp = RRESP; end
      end
      chk("rd_done", {31'b0, got_r}, 32'd1);
      ARVALID = 1'b0;
      @(posedge clk); #1;
      RREADY = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      AWADDR = '0; AWPROT = 3'b010; AWVALID = 0;
      WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
      ARADDR = '0; ARPROT = 3'b001; ARVALID = 0; RREADY = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {28'b0, AWREADY, WREADY, ARREADY, BVALID}, 32'd0);
      chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
      chk("rst_rdata", RDATA, 32'd0);
      chk("rst_leds", {28'b0, leds}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic write/read of R0
      axi_write(5'h00, 32'h2, 4'hF, 0);
      chk("r0_bresp", {30'b0, last_bresp}, 32'd0);
      axi_read(5'h00, rd, rr);
      chk("r0_rd", rd, 32'h2);
      chk("r0_rresp", {30'b0, rr}, 32'd0);

      // address first, data three cycles later
      axi_write(5'h04, 32'h1, 4'hF, 3);
      chk("split_aw_pulses", aw_pulses, 1);
      chk("split_w_pulses", w_pulses, 1);
      chk("split_b_cleared", {31'b0, b_after}, 32'd0);
      axi_read(5'h04, rd, rr);
      chk("r1_rd", rd, 32'h1);

      // subtract: 2 - 1
      axi_write(5'h0C, 32'h1, 4'hF, 0);
      axi_read(5'h0C, rd, rr);
      chk("ctrl_done_sub", rd, 32'h8000_0000);
      axi_read(5'h08, rd, rr);
      chk("r2_sub", rd, 32'h1);

      // add: 2 + 1
      axi_write(5'h0C, 32'h3, 4'hF, 0);
      axi_read(5'h0C, rd, rr);
      chk("ctrl_done_add", rd, 32'h8000_0002);
      axi_read(5'h08, rd, rr);
      chk("r2_add", rd, 32'h3);

      // 0 - 1 wraps
      axi_write(5'h00, 32'h0, 4'hF, 0);
      axi_write(5'h0C, 32'h1, 4'hF, 0);
      axi_read(5'h08, rd, rr);
      chk("r2_wrap", rd, 32'hFFFF_FFFF);

      // OP-only write keeps DONE and R2; operand writes do not touch R2
      axi_write(5'h0C, 32'h2, 4'hF, 0);
      axi_read(5'h0C, rd, rr);
      chk("ctrl_op_only", rd, 32'h8000_0002);
      axi_write(5'h00, 32'h5, 4'hF, 0);
      axi_read(5'h08, rd, rr);
      chk("r2_held", rd, 32'hFFFF_FFFF);

      // R2 and unmapped writes ignored but answered OKAY
      axi_write(5'h08, 32'h1234, 4'hF, 0);
      chk("r2_wr_bresp", {30'b0, last_bresp}, 32'd0);
      axi_read(5'h08, rd, rr);
      chk("r2_ro", rd, 32'hFFFF_FFFF);
      axi_write(5'h14, 32'hCAFE, 4'hF, 0);
      chk("unmap_bresp", {30'b0, last_bresp}, 32'd0);
      axi_read(5'h14, rd, rr);
      chk("unmap_rd", rd, 32'h0);
      chk("unmap_rresp", {30'b0, rr}, 32'd0);

      // LEDs
      chk("leds_before", {28'b0, leds}, 32'd0);
      axi_write(5'h10, 32'hF, 4'hF, 0);
      chk("leds_after", {28'b0, leds}, 32'hF);
      axi_read(5'h10, rd, rr);
      chk("led_rd", rd, 32'hF);

      // byte lanes
      axi_write(5'h00, 32'h0, 4'hF, 0);
      axi_write(5'h00, 32'hAABB_CCDD, 4'b0001, 0);
      axi_read(5'h00, rd, rr);
      chk("strb_lane0", rd, 32'h0000_00DD);
      axi_write(5'h00, 32'h1122_3344, 4'b1100, 0);
      axi_read(5'h00, rd, rr);
      chk("strb_upper", rd, 32'h1122_00DD);

      // read and write of R1 launched together: read sees the old value
      fork
         axi_write(5'h04, 32'h77, 4'hF, 0);
         axi_read(5'h04, rd_c, rr_c);
      join
      chk("concurrent_old", rd_c, 32'h1);
      axi_read(5'h04, rd, rr);
      chk("concurrent_new", rd, 32'h77);

      // reset in the middle of a write
      AWADDR = 5'h10; AWVALID = 1'b1;
      WDATA = 32'h0; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", {28'b0, AWREADY, WREADY, ARREADY, BVALID}, 32'd0);
      chk("mid_rst_rvalid", {31'b0, RVALID}, 32'd0);
      chk("mid_rst_leds", {28'b0, leds}, 32'd0);
      AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      axi_read(5'h00, rd, rr);
      chk("post_rst_r0", rd, 32'h0);
      axi_write(5'h00, 32'h55, 4'hF, 0);
      axi_read(5'h00, rd, rr);
      chk("post_rst_wr", rd, 32'h55);
      axi_read(5'h0C, rd, rr);
      chk("post_rst_ctrl", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adder_amba_top.md
ADDER_AMBA_TOP -- requirements
Module: adder_amba_top

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, the AXI4-Lite byte-address width.
REQ-003 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1 bit: asynchronous, active-high reset (asserted = 1 despite the suffix).
REQ-005 SHALL have ports S_AXI_AWADDR (in, ADDR_W), S_AXI_AWPROT (in, 3), S_AXI_AWVALID (in, 1) and S_AXI_AWREADY (out, 1), forming the write-address channel.
REQ-006 SHALL have ports S_AXI_WDATA (in, 32), S_AXI_WSTRB (in, 4), S_AXI_WVALID (in, 1) and S_AXI_WREADY (out, 1), forming the write-data channel.
REQ-007 SHALL have ports S_AXI_BRESP (out, 2), S_AXI_BVALID (out, 1) and S_AXI_BREADY (in, 1), forming the write-response channel.
REQ-008 SHALL have ports S_AXI_ARADDR (in, ADDR_W), S_AXI_ARPROT (in, 3), S_AXI_ARVALID (in, 1) and S_AXI_ARREADY (out, 1), forming the read-address channel.
REQ-009 SHALL have ports S_AXI_RDATA (out, 32), S_AXI_RRESP (out, 2), S_AXI_RVALID (out, 1) and S_AXI_RREADY (in, 1), forming the read-data channel.
REQ-010 SHALL have port o_leds, output, 4 bits, driven from LED register bits [3:0].

Function
REQ-011 SHALL decode registers on address bits [4:2]:
- 0x00 R0, operand A, RW.
- 0x04 R1, operand B, RW.
- 0x08 R2, result, RO.
- 0x0C CTRL/STATUS.
- 0x10 LED, RW.
REQ-012 SHALL lay out CTRL/STATUS as follows:
- bit0 START: write 1 to start; self-clearing; reads 0.
- bit1 OP: 1 = add, 0 = subtract; RW.
- bit31 DONE: RO.
- All other bits read 0.
REQ-013 SHALL accept AW and W independently, in any order or together; AWPROT/ARPROT are ignored.
REQ-014 AW channel SHALL assert AWREADY for exactly one cycle when AWVALID=1 and no address is pending, latch AWADDR, and accept no further address until the B handshake completes.
REQ-015 W channel SHALL assert WREADY for exactly one cycle when WVALID=1 and no data is pending, latch WDATA/WSTRB, and accept no further data until the B handshake completes.
REQ-016 Once both address and data are held, the register write SHALL occur on the next edge, with byte lanes enabled by WSTRB.
REQ-017 The write SHALL set BVALID=1 with BRESP=00 on the same edge as the register write; BVALID SHALL hold until BREADY=1, then clear.
REQ-018 Read SHALL assert ARREADY for one cycle when ARVALID=1 and RVALID=0; the next edge sets RVALID=1, RRESP=00 and RDATA=the addressed register.
REQ-019 RVALID SHALL hold until RREADY=1; RDATA SHALL hold its value until the next read address is accepted.
REQ-020 Writes to R2 and to unmapped offsets (0x14-0x1C) SHALL be ignored but still answered OKAY; unmapped reads SHALL return 0 with OKAY.
REQ-021 A CTRL write with bit0=1 SHALL store OP, clear DONE, and one cycle later load R2 with R0+R1 (OP=1) or R0-R1 (OP=0), modulo 2^32, and set DONE=1.
REQ-022 DONE SHALL remain 1 until the next start or reset.
REQ-023 Operand writes after a computation SHALL NOT alter R2 until the next start.
REQ-024 A CTRL write with bit0=0 SHALL update only OP.
REQ-025 Simultaneous read and write SHALL both complete; a read issued in the same cycle as a write returns the pre-write value.

Reset
REQ-026 While S_AXI_ARESETN=1, the block SHALL asynchronously clear the following to 0:
- all registers and DONE/OP;
- AWREADY, WREADY, BVALID, ARREADY, RVALID;
- BRESP, RRESP, RDATA, o_leds.
REQ-027 Reset asserted mid-transaction SHALL abort it with no register update; after release the block SHALL accept a new transaction immediately.

Verification
REQ-028 Write 0x2 to 0x00, complete B, read 0x00 -> RDATA=0x00000002, RRESP=00.
REQ-029 Issue AW to 0x04, drop AWVALID, then send W=0x1 -> one AWREADY pulse, one WREADY pulse, one BVALID; a read of 0x04 returns 0x00000001.
REQ-030 R0=2, R1=1, write 0x1 to 0x0C, then poll 0x0C -> bit31=1 within 2 cycles; read 0x08 returns 0x00000001.
REQ-031 Same operands, write 0x3 to 0x0C -> R2 reads 0x00000003; with R0=0, R1=1 and subtract -> R2 reads 0xFFFFFFFF.
REQ-032 Write 0xF to 0x10 -> o_leds goes from 0000 to 1111 after the write; read-back returns 0x0000000F.
REQ-033 Write 0xAABBCCDD with WSTRB=0001 to 0x00 (previously 0) -> R0 reads 0x000000DD; assert reset mid-write -> all outputs return to 0.
